// File: rtl/bus_inv_sched.sv
// Round-robin front end for one shared word-order-inverting datapath. It issues one word,
// waits out the datapath latency, returns the result and halts after MAX_ERR errors in a row.
module bus_inv_sched #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4,
    parameter int ID_W      = 2,
    parameter int LATENCY   = 1,
    parameter int MAX_ERR   = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2**ID_W-1:0]            req_valid,
    input  logic [2**ID_W*BUS_SIZE-1:0]   req_data,
    output logic [2**ID_W-1:0]            req_ready,
    output logic [BUS_SIZE-1:0]           dp_data_in,
    input  logic [BUS_SIZE-1:0]           dp_data_out,
    input  logic                          dp_error,
    output logic                          resp_valid,
    output logic [ID_W-1:0]               resp_id,
    output logic [BUS_SIZE-1:0]           resp_data,
    output logic                          resp_error,
    output logic                          halted,
    output logic [1:0]                    state
);

    localparam int NUM_REQ = 2**ID_W;
    localparam int WAIT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int ERR_W   = $clog2(MAX_ERR + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(MAX_ERR);

    generate
        if ((BUS_SIZE % WORD_SIZE) != 0 || LATENCY < 1 || MAX_ERR < 1) begin : g_bad_params
            $error("bus_inv_sched: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t                state_reg;
    logic [ID_W-1:0]       rr_ptr_reg;
    logic [ID_W-1:0]       id_reg;
    logic [WAIT_W-1:0]     wait_cnt_reg;
    logic [ERR_W-1:0]      err_cnt_reg;
    logic [ERR_W-1:0]      err_cnt_next;
    logic [BUS_SIZE-1:0]   dp_data_in_reg;
    logic                  resp_valid_reg;
    logic [ID_W-1:0]       resp_id_reg;
    logic [BUS_SIZE-1:0]   resp_data_reg;
    logic                  resp_error_reg;
    logic                  halted_reg;

    logic [BUS_SIZE-1:0]   req_words [NUM_REQ];
    logic [ID_W-1:0]       cand [NUM_REQ];
    logic [NUM_REQ-1:0]    hit;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic                  grant_en;

    // cand[gi] is the requester examined gi places after the pointer; wrap is free at 2**ID_W.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_words[gi] = req_data[gi*BUS_SIZE +: BUS_SIZE];
            assign cand[gi]      = rr_ptr_reg + ID_W'(gi);
            assign hit[gi]       = req_valid[cand[gi]];
            assign req_ready[gi] = grant_en && (winner == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found  = 1'b1;
                winner = cand[k];
            end
        end
    end

    assign grant_en = reset && (state_reg == IDLE) && found;

    always_comb begin
        err_cnt_next = '0;
        if (dp_error) begin
            err_cnt_next = (err_cnt_reg == ERR_MAX) ? ERR_MAX : err_cnt_reg + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            id_reg         <= '0;
            wait_cnt_reg   <= '0;
            err_cnt_reg    <= '0;
            dp_data_in_reg <= '0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_data_reg  <= '0;
            resp_error_reg <= 1'b0;
            halted_reg     <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        dp_data_in_reg <= req_words[winner];
                        id_reg         <= winner;
                        rr_ptr_reg     <= winner + ID_W'(1);
                        wait_cnt_reg   <= '0;
                        state_reg      <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= SAMPLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                SAMPLE: begin
                    resp_data_reg  <= dp_data_out;
                    resp_error_reg <= dp_error;
                    resp_id_reg    <= id_reg;
                    resp_valid_reg <= 1'b1;
                    err_cnt_reg    <= err_cnt_next;
                    if (err_cnt_next == ERR_MAX) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                HALT: begin
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign dp_data_in = dp_data_in_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_data  = resp_data_reg;
    assign resp_error = resp_error_reg;
    assign halted     = halted_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_bus_inv_sched.sv
// Directed bench for bus_inv_sched with a one-stage nibble-reversing datapath model.
module tb_bus_inv_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [15:0] dp_data_in;
    logic [15:0] dp_data_out;
    logic        dp_error;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [15:0] resp_data;
    logic        resp_error;
    logic        halted;
    logic [1:0]  state;
    logic        err_force = 1'b0;
    logic [15:0] dp_q;

    int checks = 0;
    int errors = 0;

    logic [15:0] words   [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [15:0] inv_exp [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

    bus_inv_sched #(
        .BUS_SIZE(16), .WORD_SIZE(4), .ID_W(2), .LATENCY(1), .MAX_ERR(3)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
        .dp_error(dp_error), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_error(resp_error), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rev_words(input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = w[(3-k)*4 +: 4];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) dp_q <= '0;
        else        dp_q <= rev_words(dp_data_in);
    end
    assign dp_data_out = dp_q;
    assign dp_error    = err_force;

    always @(negedge clk) begin
        if (resp_valid)
            $display("txn id=%0d data=%h err=%0d", resp_id, resp_data, resp_error);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        err_force = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 4'b1111;
        req_data = {words[3], words[2], words[1], words[0]};
        step();
        step();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (dp_data_in !== 16'h0000) begin errors++; $display("FAIL reset_dp_in got %h want 0000", dp_data_in); end
        checks++; if ({resp_valid, resp_id, resp_data, resp_error, halted} !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b id=%0d d=%h e=%b h=%b want all 0",
                               resp_valid, resp_id, resp_data, resp_error, halted); end
        req_valid = '0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_data[2*16 +: 16] = 16'h1234;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        checks++; if (dp_data_in !== 16'h1234) begin errors++; $display("FAIL single_dp_in got %h want 1234", dp_data_in); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL single_wait got %0d want 1", state); end
        step();
        checks++; if (state !== 2'd2 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_sample got st=%0d v=%b want st=2 v=0", state, resp_valid); end
        step();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 16'h4321 || resp_error !== 1'b0) begin
            errors++; $display("FAIL single_resp got v=%b id=%0d d=%h e=%b want v=1 id=2 d=4321 e=0",
                               resp_valid, resp_id, resp_data, resp_error); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL single_idle got %0d want 0", state); end
        step();
        checks++; if (resp_valid !== 1'b0 || resp_data !== 16'h4321) begin
            errors++; $display("FAIL single_hold got v=%b d=%h want v=0 d=4321", resp_valid, resp_data); end
    endtask

    task automatic test_saturated();
        logic [3:0] exp_rdy;
        int pid;
        do_reset();
        req_data = {words[3], words[2], words[1], words[0]};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++; if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL sat_grant%0d got %b want %b", k, req_ready, exp_rdy); end
            if (k > 0) begin
                pid = (k - 1) % 4;
                checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(pid) || resp_data !== inv_exp[pid]) begin
                    errors++; $display("FAIL sat_resp%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                                       k - 1, resp_valid, resp_id, resp_data, pid, inv_exp[pid]); end
            end
            step();
            checks++; if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL sat_busy%0d got %b want 0000", k, req_ready); end
            step();
            step();
        end
        req_valid = '0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 16'h3210) begin
            errors++; $display("FAIL sat_resp4 got v=%b id=%0d d=%h want v=1 id=0 d=3210",
                               resp_valid, resp_id, resp_data); end
        step();
    endtask

    task automatic test_pointer_order();
        do_reset();
        req_data = {words[3], words[2], words[1], words[0]};
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ptr_g1 got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ptr_g3 got %b want 1000", req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 16'h7654) begin
            errors++; $display("FAIL ptr_r1 got v=%b id=%0d d=%h want v=1 id=1 d=7654", resp_valid, resp_id, resp_data); end
        step();
        req_valid = 4'b0001;
        step();
        step();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ptr_g0 got %b want 0001", req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== 16'hFEDC) begin
            errors++; $display("FAIL ptr_r3 got v=%b id=%0d d=%h want v=1 id=3 d=fedc", resp_valid, resp_id, resp_data); end
        step();
        req_valid = '0;
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 16'h3210) begin
            errors++; $display("FAIL ptr_r0 got v=%b id=%0d d=%h want v=1 id=0 d=3210", resp_valid, resp_id, resp_data); end
        step();
    endtask

    task automatic test_err_threshold();
        do_reset();
        req_data = {words[3], words[2], words[1], words[0]};
        err_force = 1'b1;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL err_g0 got %b want 0001", req_ready); end
        for (int k = 0; k < 2; k++) begin
            step(); step(); step();
            checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1 || state !== 2'd0 || halted !== 1'b0) begin
                errors++; $display("FAIL err_resp%0d got v=%b e=%b st=%0d h=%b want v=1 e=1 st=0 h=0",
                                   k, resp_valid, resp_error, state, halted); end
        end
        step(); step(); step();
        checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin
            errors++; $display("FAIL err_resp2 got v=%b e=%b want v=1 e=1", resp_valid, resp_error); end
        checks++; if (state !== 2'd3 || halted !== 1'b1 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL err_halt got st=%0d h=%b rdy=%b want st=3 h=1 rdy=0000", state, halted, req_ready); end
        step();
        step();
        checks++; if (state !== 2'd3 || halted !== 1'b1 || req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL err_stay got st=%0d h=%b rdy=%b v=%b want st=3 h=1 rdy=0000 v=0",
                               state, halted, req_ready, resp_valid); end
        req_valid = '0;
        err_force = 1'b0;
    endtask

    task automatic test_halt_recovery();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (state !== 2'd0 || halted !== 1'b0 || resp_valid !== 1'b0 || dp_data_in !== 16'h0000) begin
            errors++; $display("FAIL rec_reset got st=%0d h=%b v=%b dp=%h want st=0 h=0 v=0 dp=0000",
                               state, halted, resp_valid, dp_data_in); end
        err_force = 1'b1;
        req_data[2*16 +: 16] = 16'h1234;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rec_g2 got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_data !== 16'h4321 || state !== 2'd0) begin
            errors++; $display("FAIL rec_err1 got v=%b e=%b d=%h st=%0d want v=1 e=1 d=4321 st=0",
                               resp_valid, resp_error, resp_data, state); end
        err_force = 1'b0;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rec_g3 got %b want 1000", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== 16'hFEDC || resp_error !== 1'b0) begin
            errors++; $display("FAIL rec_clean got v=%b id=%0d d=%h e=%b want v=1 id=3 d=fedc e=0",
                               resp_valid, resp_id, resp_data, resp_error); end
        step();
    endtask

    task automatic test_no_halt_pattern();
        logic [3:0] pat;
        do_reset();
        req_data = {words[3], words[2], words[1], words[0]};
        pat = 4'b1101;
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            err_force = pat[k];
            #1;
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pat_g%0d got %b want 0010", k, req_ready); end
            step(); step(); step();
            checks++; if (resp_valid !== 1'b1 || resp_error !== pat[k] || state !== 2'd0 || halted !== 1'b0) begin
                errors++; $display("FAIL pat_resp%0d got v=%b e=%b st=%0d h=%b want v=1 e=%b st=0 h=0",
                                   k, resp_valid, resp_error, state, halted, pat[k]); end
        end
        req_valid = '0;
        err_force = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = {words[3], words[2], words[1], words[0]};
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_g1 got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        reset = 1'b0;
        step();
        checks++; if (state !== 2'd0 || dp_data_in !== 16'h0000 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_clear got st=%0d dp=%h v=%b want st=0 dp=0000 v=0", state, dp_data_in, resp_valid); end
        reset = 1'b1;
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr0 got %b want 0010", req_ready); end
        step();
        req_valid = 4'b1000;
        checks++; if (resp_valid !== 1'b0 || dp_data_in !== 16'h4567) begin
            errors++; $display("FAIL mid_noresp got v=%b dp=%h want v=0 dp=4567", resp_valid, dp_data_in); end
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 16'h7654 || req_ready !== 4'b1000) begin
            errors++; $display("FAIL mid_resp got v=%b id=%0d d=%h rdy=%b want v=1 id=1 d=7654 rdy=1000",
                               resp_valid, resp_id, resp_data, req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== 16'hFEDC) begin
            errors++; $display("FAIL mid_resp3 got v=%b id=%0d d=%h want v=1 id=3 d=fedc", resp_valid, resp_id, resp_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturated();
        test_pointer_order();
        test_err_threshold();
        test_halt_recovery();
        test_no_halt_pattern();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_inv_sched.md
# bus_inv_sched

Round-robin scheduler that shares one word-order-inverting datapath (register bank plus LSW/MSW checking FSM) among up to 2**ID_W requesters. It accepts one bus word per transaction through a valid/ready handshake and drives it into the datapath. It waits out the datapath latency, then returns the inverted word, the error flag and the requester ID. It counts consecutive datapath errors and halts the shared resource when a threshold is reached.

## Interface
- BUS_SIZE, 16, bus width in bits; must equal the datapath's BUS_SIZE.
- WORD_SIZE, 4, datapath word size; BUS_SIZE must be a multiple of it.
- ID_W, 2, requester ID width; NUM_REQ = 2**ID_W.
- LATENCY, 1, datapath register stages from dp_data_in to dp_data_out; must be ≥1.
- MAX_ERR, 3, number of consecutive errored transactions that forces HALT; must be ≥1.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_data  in  NUM_REQ*BUS_SIZE  requester i word at [i*BUS_SIZE +: BUS_SIZE].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- dp_data_in  out  BUS_SIZE  registered word driven into the datapath.
- dp_data_out  in  BUS_SIZE  inverted word from the datapath.
- dp_error  in  1  datapath FSM error flag.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  ID_W  ID of the requester being answered.
- resp_data  out  BUS_SIZE  captured dp_data_out.
- resp_error  out  1  captured dp_error.
- halted  out  1  high in HALT.
- state  out  2  current state, for debug.

## Operation
- States:
  - IDLE = 2'd0
  - WAIT = 2'd1
  - SAMPLE = 2'd2
  - HALT = 2'd3
- Reset values: state = IDLE; rr_ptr = 0; wait counter = 0; err_cnt = 0; dp_data_in = 0. resp_valid, resp_id, resp_data, resp_error and halted are all 0. req_ready = 0 whenever reset is low.
- Winner selection: the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- IDLE:
  - If any req_valid is set, req_ready[winner] = 1 combinationally in that cycle.
  - On the edge: dp_data_in <= that requester's word; the winner ID is latched; rr_ptr <= winner+1 (wraps to 0); wait counter <= 0; next state is WAIT.
  - With no request, IDLE holds and req_ready = 0.
- Only IDLE asserts req_ready. Requesters hold req_valid and req_data stable until granted. Deasserting req_valid before grant is legal; the request is simply not seen.
- WAIT: lasts exactly LATENCY cycles, counted by the wait counter, then moves to SAMPLE. dp_data_in holds its value.
- SAMPLE, on the edge:
  - resp_data <= dp_data_out; resp_error <= dp_error; resp_id <= latched ID; resp_valid <= 1.
  - If dp_error = 1: err_cnt <= err_cnt+1, saturating at MAX_ERR. Otherwise err_cnt <= 0.
  - If the updated err_cnt equals MAX_ERR, the next state is HALT; otherwise IDLE.
- resp_valid is 0 in every cycle not directly following SAMPLE. resp_data, resp_id and resp_error hold their values until the next SAMPLE.
- HALT: terminal. halted = 1 from the first HALT cycle onward; req_ready = 0. Only reset exits HALT.
- The scheduler never drives datapath reset. The datapath shares clk and reset.

## Timing
- Grant in cycle t; dp_data_in is valid in t+1.
- The datapath captures the word at the end of cycle t+LATENCY, so dp_data_out is valid in cycle t+LATENCY+1 (the SAMPLE cycle).
- resp_valid is high in cycle t+LATENCY+2. State is IDLE in that same cycle, so a new grant can coincide with resp_valid.
- Throughput: one transaction per LATENCY+2 cycles (3 for the defaults).
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting; there is no starvation under round-robin.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset low in any state, including mid-WAIT or SAMPLE: at the next edge all registers take their reset values. The in-flight transaction is dropped, no resp_valid follows, and the datapath word is cleared.

## Test plan
- Single request: after reset, req_valid = 4'b0100 with word 16'h1234 in cycle 0.
  - req_ready = 4'b0100 in cycle 0.
  - dp_data_in = 16'h1234 in cycle 1.
  - Cycle 3: resp_valid = 1, resp_id = 2, resp_data = 16'h4321, resp_error = 0.
- Saturated load: all four requesters held valid. Grants go 0,1,2,3,0 in cycles 0,3,6,9,12, and each response lands 3 cycles after its grant.
- Pointer order: grant requester 1, then raise requests 0 and 3 together. Requester 3 is granted next, then requester 0.
- Error threshold: datapath model forces dp_error = 1 for three consecutive transactions.
  - resp_error = 1 on each of the three responses.
  - After the third SAMPLE: state = 2'd3, halted = 1, req_ready stays 0 despite pending requests.
  - Negative case: the pattern error, clean, error, error does not halt.
- Reset mid-transaction: reset low during WAIT. Next cycle: state = 0, dp_data_in = 0, resp_valid stays 0. After release, the first grant goes to the lowest-index requester from rr_ptr = 0.
- HALT recovery: reset low one cycle in HALT. halted = 0, err_cnt = 0, and the next request completes normally.
